// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the master and the register slave.
// Holds the FSM state encoding and the response codes.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4,
        S_RSP     = 3'd5
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite master: turns single valid/ready commands into AW/W/B or AR/R
// transactions, one outstanding at a time, with a saturating error count.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int         P_M_AXI_DATA_WIDTH = 32,
    parameter int         P_M_AXI_ADDR_WIDTH = 4,
    parameter logic [2:0] P_M_AXI_PROT       = 3'b000,
    parameter int         P_ERR_CNT_WIDTH    = 8
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            i_cmd_valid,
    output logic                            o_cmd_ready,
    input  logic                            i_cmd_wr,
    input  logic [P_M_AXI_ADDR_WIDTH-1:0]   i_cmd_addr,
    input  logic [P_M_AXI_DATA_WIDTH-1:0]   i_cmd_wdata,
    input  logic [P_M_AXI_DATA_WIDTH/8-1:0] i_cmd_wstrb,
    output logic                            o_rsp_valid,
    input  logic                            i_rsp_ready,
    output logic                            o_rsp_wr,
    output logic [P_M_AXI_DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic [1:0]                      o_rsp_resp,
    output logic                            o_busy,
    output logic [P_ERR_CNT_WIDTH-1:0]      o_err_cnt,
    output logic [P_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [P_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [P_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [P_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [P_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam int DW = P_M_AXI_DATA_WIDTH;
    localparam int AW = P_M_AXI_ADDR_WIDTH;
    localparam int SW = P_M_AXI_DATA_WIDTH / 8;
    localparam int CW = P_ERR_CNT_WIDTH;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [SW-1:0]   wstrb_q, wstrb_d;
    logic            awvalid_q, awvalid_d;
    logic            wvalid_q, wvalid_d;
    logic            bready_q, bready_d;
    logic            arvalid_q, arvalid_d;
    logic            rready_q, rready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_wr_q, rsp_wr_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      resp_q, resp_d;
    logic [CW-1:0]   err_q, err_d;
    logic            aw_done, w_done;
    logic            cap_en;
    logic [1:0]      cap_resp;

    // A channel whose VALID is already low finished its handshake earlier.
    assign aw_done = !awvalid_q || M_AXI_AWREADY;
    assign w_done  = !wvalid_q || M_AXI_WREADY;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_wr_d    = rsp_wr_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        cap_en      = 1'b0;
        cap_resp    = RESP_OKAY;
        unique case (state_q)
            S_IDLE: begin
                if (i_cmd_valid) begin
                    addr_d  = i_cmd_addr;
                    wdata_d = i_cmd_wdata;
                    wstrb_d = i_cmd_wstrb;
                    if (i_cmd_wr) begin
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_RD_ADDR;
                    end
                end
            end
            S_WR: begin
                if (M_AXI_AWREADY) awvalid_d = 1'b0;
                if (M_AXI_WREADY)  wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (M_AXI_BVALID && bready_q) begin
                    cap_en      = 1'b1;
                    cap_resp    = M_AXI_BRESP;
                    resp_d      = M_AXI_BRESP;
                    rsp_wr_d    = 1'b1;
                    rdata_d     = '0;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RD_ADDR: begin
                if (arvalid_q && M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (M_AXI_RVALID && rready_q) begin
                    cap_en      = 1'b1;
                    cap_resp    = M_AXI_RRESP;
                    resp_d      = M_AXI_RRESP;
                    rsp_wr_d    = 1'b0;
                    rdata_d     = M_AXI_RDATA;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RSP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (cap_en && cap_resp != RESP_OKAY && err_q != {CW{1'b1}})
            err_d = err_q + CW'(1);
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_wr_q    <= rsp_wr_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            err_q       <= err_d;
        end
    end

    assign o_cmd_ready   = (state_q == S_IDLE);
    assign o_busy        = (state_q != S_IDLE);
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_wr      = rsp_wr_q;
    assign o_rsp_rdata   = rdata_q;
    assign o_rsp_resp    = resp_q;
    assign o_err_cnt     = err_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWPROT  = P_M_AXI_PROT;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARPROT  = P_M_AXI_PROT;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: drives inputs on the falling edge
// and checks registered outputs there, half a cycle after each rising edge.
module tb_axi_lite_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_wr;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy;
    logic [7:0]  err_cnt;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int errors = 0;

    axi_lite_master dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rst_n),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_wr      (cmd_wr),
        .i_cmd_addr    (cmd_addr),
        .i_cmd_wdata   (cmd_wdata),
        .i_cmd_wstrb   (cmd_wstrb),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_wr      (rsp_wr),
        .o_rsp_rdata   (rsp_rdata),
        .o_rsp_resp    (rsp_resp),
        .o_busy        (busy),
        .o_err_cnt     (err_cnt),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWPROT  (awprot),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a command for one cycle; returns at the falling edge after
    // the rising edge that accepted it.
    task automatic issue(input logic wr, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Zero-wait slave completing a write whose AW/W just went valid.
    task automatic finish_write(input logic [3:0] a, input logic [31:0] d,
                                input logic [1:0] br);
        chk("wr_awvalid", awvalid, 1'b1);
        chk("wr_wvalid", wvalid, 1'b1);
        chk("wr_awaddr", awaddr, a);
        chk("wr_wdata", wdata, d);
        awready = 1'b1;
        wready  = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        wready  = 1'b0;
        chk("wr_aw_drop", awvalid, 1'b0);
        chk("wr_w_drop", wvalid, 1'b0);
        chk("wr_bready", bready, 1'b1);
        bvalid = 1'b1;
        bresp  = br;
        @(negedge clk);
        bvalid = 1'b0;
        bresp  = 2'b00;
        chk("wr_bready_drop", bready, 1'b0);
        chk("wr_rsp_valid", rsp_valid, 1'b1);
        chk("wr_rsp_resp", rsp_resp, br);
        chk("wr_rsp_wr", rsp_wr, 1'b1);
        chk("wr_rsp_rdata", rsp_rdata, 32'h0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("wr_rsp_done", rsp_valid, 1'b0);
        chk("wr_idle", cmd_ready, 1'b1);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = 4'h0;
        cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0;
        rsp_ready = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        bresp     = 2'b00;
        bvalid    = 1'b0;
        arready   = 1'b0;
        rdata     = 32'h0;
        rresp     = 2'b00;
        rvalid    = 1'b0;

        @(negedge clk);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_err_cnt", err_cnt, 8'd0);
        chk("rst_awaddr", awaddr, 4'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Stray BVALID in IDLE is ignored
        bvalid = 1'b1;
        bresp  = 2'b10;
        @(negedge clk);
        bvalid = 1'b0;
        bresp  = 2'b00;
        chk("stray_bready", bready, 1'b0);
        chk("stray_rsp", rsp_valid, 1'b0);
        chk("stray_err", err_cnt, 8'd0);

        // Write, AW and W ready together, OKAY
        chk("w1_cmd_ready", cmd_ready, 1'b1);
        issue(1'b1, 4'h4, 32'hDEADBEEF, 4'hF);
        chk("w1_busy", busy, 1'b1);
        chk("w1_cmd_ready", cmd_ready, 1'b0);
        chk("w1_wstrb", wstrb, 4'hF);
        chk("w1_awprot", awprot, 3'b000);
        finish_write(4'h4, 32'hDEADBEEF, 2'b00);
        chk("w1_err", err_cnt, 8'd0);

        // Write with WREADY three cycles after AWREADY
        issue(1'b1, 4'hC, 32'hCAFEF00D, 4'h3);
        chk("w2_awvalid", awvalid, 1'b1);
        chk("w2_wvalid", wvalid, 1'b1);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("w2_aw_drop", awvalid, 1'b0);
            chk("w2_w_hold", wvalid, 1'b1);
            chk("w2_wdata_hold", wdata, 32'hCAFEF00D);
            chk("w2_wstrb_hold", wstrb, 4'h3);
            chk("w2_bready_low", bready, 1'b0);
            if (i == 2) wready = 1'b1;
            @(negedge clk);
        end
        wready = 1'b0;
        chk("w2_w_drop", wvalid, 1'b0);
        chk("w2_bready", bready, 1'b1);
        @(negedge clk);
        chk("w2_bready_wait", bready, 1'b1);
        chk("w2_no_rsp", rsp_valid, 1'b0);
        bvalid = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        chk("w2_rsp_valid", rsp_valid, 1'b1);
        chk("w2_rsp_wr", rsp_wr, 1'b1);
        chk("w2_rsp_resp", rsp_resp, 2'b00);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("w2_done", rsp_valid, 1'b0);

        // Read with ARREADY delayed two cycles
        issue(1'b0, 4'h8, 32'h0, 4'h0);
        chk("r1_arvalid", arvalid, 1'b1);
        chk("r1_araddr", araddr, 4'h8);
        chk("r1_arprot", arprot, 3'b000);
        chk("r1_rready_low", rready, 1'b0);
        chk("r1_awvalid_low", awvalid, 1'b0);
        @(negedge clk);
        chk("r1_arvalid_hold", arvalid, 1'b1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("r1_ar_drop", arvalid, 1'b0);
        chk("r1_rready", rready, 1'b1);
        rvalid = 1'b1;
        rdata  = 32'h12345678;
        @(negedge clk);
        rvalid = 1'b0;
        rdata  = 32'h0;
        chk("r1_rready_drop", rready, 1'b0);
        chk("r1_rsp_valid", rsp_valid, 1'b1);
        chk("r1_rsp_rdata", rsp_rdata, 32'h12345678);
        chk("r1_rsp_resp", rsp_resp, 2'b00);
        chk("r1_rsp_wr", rsp_wr, 1'b0);

        // Hold the response 5 cycles while a write command waits
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = 4'h2;
        cmd_wdata = 32'hA5A5A5A5;
        cmd_wstrb = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", rsp_valid, 1'b1);
            chk("hold_rdata", rsp_rdata, 32'h12345678);
            chk("hold_wr", rsp_wr, 1'b0);
            chk("hold_cmd_ready", cmd_ready, 1'b0);
            chk("hold_awvalid", awvalid, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("hold_rsp_gone", rsp_valid, 1'b0);
        chk("hold_cmd_ready_back", cmd_ready, 1'b1);
        chk("hold_not_early", awvalid, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b0;
        finish_write(4'h2, 32'hA5A5A5A5, 2'b00);

        // SLVERR on 300 writes saturates the counter at 255
        issue(1'b1, 4'h0, 32'h1, 4'h1);
        finish_write(4'h0, 32'h1, 2'b10);
        chk("err_first", err_cnt, 8'd1);
        for (int i = 1; i < 300; i++) begin
            issue(1'b1, 4'h0, 32'h1, 4'h1);
            finish_write(4'h0, 32'h1, 2'b10);
            if (i == 254) chk("err_at_255", err_cnt, 8'd255);
        end
        chk("err_sat", err_cnt, 8'd255);

        // Reset while AWVALID is high
        issue(1'b1, 4'h6, 32'h55AA55AA, 4'hF);
        chk("rm_awvalid", awvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_awvalid_0", awvalid, 1'b0);
        chk("rm_wvalid_0", wvalid, 1'b0);
        chk("rm_awaddr_0", awaddr, 4'h0);
        chk("rm_wdata_0", wdata, 32'h0);
        chk("rm_err_0", err_cnt, 8'd0);
        chk("rm_busy_0", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rm_no_rsp", rsp_valid, 1'b0);
            chk("rm_idle", cmd_ready, 1'b1);
            chk("rm_awvalid_idle", awvalid, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
